ftrace_event_recorder: RTL and testbench
========================================

// Module: ftrace_event_recorder
// PURPOSE
//  Consumer end of the commit-stage function-trace stream. Watches retired instructions, classifies
//  calls and returns, and tracks call depth. Buffers events in a FIFO that a debug/trace reader drains
//  via valid/ready. Sits beside the commit stage, in place of the simulation-only call-trace sink.
// PARAMETERS
//  XLEN   32  width of pc/target/inst fields
//  DEPTH  16  event FIFO entries; power of 2, >=2
//  DW     8   call-depth counter width
// PORTS
//  clock          in   1      single clock, rising edge
//  reset          in   1      asynchronous, active-low
//  commit_valid   in   1      one instruction retires this cycle
//  commit_pc      in   XLEN   pc of retiring instruction
//  commit_nextpc  in   XLEN   architectural next pc (jump target)
//  commit_inst    in   32     instruction word
//  out_valid      out  1      head event available
//  out_ready      in   1      reader accepts head event
//  out_kind       out  2      00 call, 01 return, 11 tail call (FTRACE_TAIL_CALL_EN only), 10 reserved
//  out_pc         out  XLEN   pc of the jump
//  out_target     out  XLEN   jump target
//  out_depth      out  DW     call depth tagged on event
//  fifo_count     out  $clog2(DEPTH)+1  occupied entries
//  drop_cnt       out  16     events lost to full FIFO, saturating
//  underflow      out  1      sticky: return seen at depth 0
// BEHAVIOUR
//  - Reset (async, reset==0): FIFO empty, out_valid=0, fifo_count=0, depth=0, drop_cnt=0, underflow=0.
//    Reset mid-operation discards all buffered events.
//  - Classification (combinational, gated by commit_valid). opc=inst[6:0], rd=inst[11:7], rs1=inst[19:15].
//    isLink(r) = r==1 || r==5.
//    call:   opc==1101111 (JAL), or opc==1100111 (JALR), with isLink(rd).
//    return: opc==1100111, rd==0, isLink(rs1), inst[31:20]==0.
//    Anything else is ignored; no state change.
//  - Depth: call tags the pre-increment depth, then depth++ (saturates at 2^DW-1).
//    return decrements first (saturates at 0) and tags the post-decrement depth, so a matched
//    call/return pair carries equal out_depth. Return at depth 0 sets underflow; tag is 0.
//  - Depth updates on every classified event, whether or not the FIFO accepts it.
//  - FIFO: push on classified event. Event at commit cycle N is visible on out_* at N+1 at the earliest.
//    Pop when out_valid && out_ready. out_* are driven from the head entry; they hold stable while
//    out_valid && !out_ready.
//  - Full (fifo_count==DEPTH): push is accepted only if a pop happens in the same cycle, and count is
//    unchanged. Otherwise the event is dropped and drop_cnt++ (saturates at 16'hFFFF).
//  - Empty: out_valid=0; out_ready is ignored. Push on an empty FIFO never bypasses to out_* in the
//    same cycle.
//  - Pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; the MSB distinguishes full from empty.
// CONFIGURATION
//  FTRACE_TAIL_CALL_EN defined: opc==1100111, rd==0, !isLink(rs1) is a tail call. It records kind 11
//    and tags the current depth; depth is unchanged.
//  FTRACE_TAIL_CALL_EN undefined: that instruction is ignored; kind 11 is never produced.
// STRUCTURE
//  ftrace_pkg: kind encodings (KIND_CALL/RET/TAIL), OPC_JAL/OPC_JALR, REG_RA=1/REG_T0=5,
//    packed event struct {kind, pc, target, depth}.
//  Sub-module ftrace_sync_fifo: parameterised DEPTH x event-struct FIFO with push/pop/count/full/empty.
//    Classifier, depth counter and drop counter stay in the top level.
// TESTING
//  1 jal ra at pc=0x80000000, target 0x80000100, then ret (0x00008067) -> two events:
//    {call, pc 0x80000000, target 0x80000100, depth 0}, then {ret, depth 0}; final depth 0.
//  2 three nested calls, out_ready=0 -> fifo_count=3, depths 0,1,2. Three returns then release
//    out_ready -> depths 2,1,0 in order.
//  3 DEPTH+2 calls with out_ready=0 -> fifo_count=DEPTH, drop_cnt=2. Push with out_ready=1 at full
//    -> accepted, count stays DEPTH.
//  4 ret at depth 0 -> underflow=1, event depth 0, depth stays 0. Sticky until reset.
//  5 jalr x0,0(a5) (0x00078067) -> with FTRACE_TAIL_CALL_EN: kind 11, depth unchanged.
//    Without it: no event. add/lw/jal x0 (0x0000006F) -> no event in either build.
//  6 assert reset low with 5 events queued -> next cycle out_valid=0, fifo_count=0, drop_cnt=0.

Source files
------------

// File: rtl/ftrace_pkg.sv
// Shared types and constants for the function-trace event recorder: event kinds,
// RISC-V jump opcodes, link-register numbers and the buffered event record.
package ftrace_pkg;

  localparam int FT_XLEN = 32;
  localparam int FT_DW   = 8;

  typedef enum logic [1:0] {
    KIND_CALL = 2'b00,
    KIND_RET  = 2'b01,
    KIND_RSVD = 2'b10,
    KIND_TAIL = 2'b11
  } ftrace_kind_e;

  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [4:0] REG_RA   = 5'd1;
  localparam logic [4:0] REG_T0   = 5'd5;

  typedef struct packed {
    ftrace_kind_e         kind;
    logic [FT_XLEN-1:0]   pc;
    logic [FT_XLEN-1:0]   target;
    logic [FT_DW-1:0]     depth;
  } ftrace_event_t;

  // ra and t0 are the two registers the calling convention treats as link registers
  function automatic logic is_link(input logic [4:0] r);
    return (r == REG_RA) || (r == REG_T0);
  endfunction

endpackage

// File: rtl/ftrace_sync_fifo.sv
// Synchronous event FIFO; pointers carry one extra wrap bit so full and empty differ.
module ftrace_sync_fifo
  import ftrace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  ftrace_event_t            i_data,
  output ftrace_event_t            o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   r_wrPtr;
  logic [AW:0]   r_rdPtr;
  ftrace_event_t r_mem [DEPTH];
  logic          w_doPush;
  logic          w_doPop;

  assign o_count  = r_wrPtr - r_rdPtr;
  assign o_full   = (o_count == (AW + 1)'(DEPTH));
  assign o_empty  = (r_wrPtr == r_rdPtr);
  assign w_doPop  = i_pop && !o_empty;
  // A full FIFO still takes a push when the head leaves in the same cycle
  assign w_doPush = i_push && (!o_full || w_doPop);
  assign o_data   = r_mem[r_rdPtr[AW-1:0]];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_doPush) r_mem[r_wrPtr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/ftrace_event_recorder.sv
// Classifies retiring jumps into call/return events, tracks call depth and buffers events.
// Optional macro FTRACE_TAIL_CALL_EN records jalr x0 through a non-link register as a tail call.
module ftrace_event_recorder
  import ftrace_pkg::*;
#(
  parameter int XLEN  = FT_XLEN,
  parameter int DEPTH = 16,
  parameter int DW    = FT_DW
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     commit_valid,
  input  logic [XLEN-1:0]          commit_pc,
  input  logic [XLEN-1:0]          commit_nextpc,
  input  logic [31:0]              commit_inst,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               out_kind,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_target,
  output logic [DW-1:0]            out_depth,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [15:0]              drop_cnt,
  output logic                     underflow
);

  logic [6:0]    w_opc;
  logic [4:0]    w_rd;
  logic [4:0]    w_rs1;
  logic          w_unusedFunct3;
  logic          w_isCall;
  logic          w_isRet;
  logic          w_isTail;
  logic          w_evt;
  ftrace_kind_e  w_kind;
  logic [DW-1:0] w_tag;
  logic [DW-1:0] w_depthNext;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  ftrace_event_t w_pushData;
  ftrace_event_t w_head;
  logic [DW-1:0] r_depth;
  logic [15:0]   r_dropCnt;
  logic          r_underflow;

  assign w_opc          = commit_inst[6:0];
  assign w_rd           = commit_inst[11:7];
  assign w_rs1          = commit_inst[19:15];
  assign w_unusedFunct3 = ^commit_inst[14:12];

  assign w_isCall = commit_valid && ((w_opc == OPC_JAL) || (w_opc == OPC_JALR)) && is_link(w_rd);
  assign w_isRet  = commit_valid && (w_opc == OPC_JALR) && (w_rd == 5'd0) && is_link(w_rs1)
                    && (commit_inst[31:20] == 12'd0);
`ifdef FTRACE_TAIL_CALL_EN
  assign w_isTail = commit_valid && (w_opc == OPC_JALR) && (w_rd == 5'd0) && !is_link(w_rs1);
`else
  assign w_isTail = 1'b0;
`endif
  assign w_evt = w_isCall || w_isRet || w_isTail;

  // Calls tag the depth before entering; returns tag after leaving, so pairs match
  always_comb begin
    w_kind      = KIND_CALL;
    w_tag       = r_depth;
    w_depthNext = r_depth;
    if (w_isCall) begin
      w_kind      = KIND_CALL;
      w_depthNext = (r_depth == {DW{1'b1}}) ? r_depth : r_depth + 1'b1;
    end else if (w_isRet) begin
      w_kind      = KIND_RET;
      w_depthNext = (r_depth == '0) ? '0 : r_depth - 1'b1;
      w_tag       = w_depthNext;
    end else if (w_isTail) begin
      w_kind      = KIND_TAIL;
    end
  end

  assign w_pop      = out_valid && out_ready;
  assign w_pushData = '{kind: w_kind, pc: commit_pc, target: commit_nextpc, depth: w_tag};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_depth     <= '0;
      r_dropCnt   <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_depth <= w_depthNext;
      if (w_isRet && (r_depth == '0)) r_underflow <= 1'b1;
      if (w_evt && w_full && !w_pop && (r_dropCnt != 16'hFFFF)) r_dropCnt <= r_dropCnt + 1'b1;
    end
  end

  ftrace_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_evt),
    .i_pop   (w_pop),
    .i_data  (w_pushData),
    .o_data  (w_head),
    .o_count (fifo_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign out_valid  = !w_empty;
  assign out_kind   = w_head.kind;
  assign out_pc     = w_head.pc;
  assign out_target = w_head.target;
  assign out_depth  = w_head.depth;
  assign drop_cnt   = r_dropCnt;
  assign underflow  = r_underflow;

endmodule

// File: tb/tb_ftrace_event_recorder.sv
// Scoreboard bench for ftrace_event_recorder: directed scenarios then random jumps,
// checked against a queue-based model of depth, FIFO occupancy and drops.
module tb_ftrace_event_recorder;

  localparam int DEPTH = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic [31:0] commit_nextpc;
  logic [31:0] commit_inst;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_kind;
  logic [31:0] out_pc;
  logic [31:0] out_target;
  logic [7:0]  out_depth;
  logic [4:0]  fifo_count;
  logic [15:0] drop_cnt;
  logic        underflow;

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] pc;
    logic [31:0] target;
    logic [7:0]  depth;
  } exp_t;

  exp_t expQ[$];
  int   mCount;
  int   mDepth;
  int   mDrop;
  bit   mUnderflow;
  int   errors = 0;
  int   checks = 0;

  ftrace_event_recorder #(.XLEN(32), .DEPTH(DEPTH), .DW(8)) dut (
    .clock         (clock),
    .reset         (reset),
    .commit_valid  (commit_valid),
    .commit_pc     (commit_pc),
    .commit_nextpc (commit_nextpc),
    .commit_inst   (commit_inst),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_kind      (out_kind),
    .out_pc        (out_pc),
    .out_target    (out_target),
    .out_depth     (out_depth),
    .fifo_count    (fifo_count),
    .drop_cnt      (drop_cnt),
    .underflow     (underflow)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Returns 0 call, 1 return, 3 tail call, -1 not an event
  function automatic int classify(input logic [31:0] inst);
    logic [6:0] opc;
    logic [4:0] rd;
    logic [4:0] rs1;
    bit linkRd;
    bit linkRs1;
    opc = inst[6:0];
    rd  = inst[11:7];
    rs1 = inst[19:15];
    linkRd  = (rd == 5'd1) || (rd == 5'd5);
    linkRs1 = (rs1 == 5'd1) || (rs1 == 5'd5);
    if ((opc == 7'h6F || opc == 7'h67) && linkRd) return 0;
    if (opc == 7'h67 && rd == 5'd0 && linkRs1 && inst[31:20] == 12'd0) return 1;
`ifdef FTRACE_TAIL_CALL_EN
    if (opc == 7'h67 && rd == 5'd0 && !linkRs1) return 3;
`endif
    return -1;
  endfunction

  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] nextpc,
                               input logic [31:0] inst, input logic rdy);
    int   kind;
    bit   pop;
    exp_t e;
    commit_valid  = v;
    commit_pc     = pc;
    commit_nextpc = nextpc;
    commit_inst   = inst;
    out_ready     = rdy;
    pop  = (mCount > 0) && rdy;
    kind = v ? classify(inst) : -1;
    @(posedge clock);
    if (kind >= 0) begin
      e.kind   = 2'(kind);
      e.pc     = pc;
      e.target = nextpc;
      if (kind == 0) begin
        e.depth = 8'(mDepth);
        if (mDepth < 255) mDepth++;
      end else if (kind == 1) begin
        if (mDepth == 0) mUnderflow = 1'b1;
        else mDepth--;
        e.depth = 8'(mDepth);
      end else begin
        e.depth = 8'(mDepth);
      end
      if (mCount < DEPTH || pop) begin
        expQ.push_back(e);
        mCount++;
      end else if (mDrop < 65535) begin
        mDrop++;
      end
    end
    if (pop) mCount--;
    #1;
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, rdy);
  endtask

  task automatic callAt(input logic [31:0] pc, input logic rdy);
    applyStimulus(1'b1, pc, pc + 32'h100, 32'h100000EF, rdy);
  endtask

  task automatic retAt(input logic [31:0] pc, input logic rdy);
    applyStimulus(1'b1, pc, pc + 32'h4, 32'h00008067, rdy);
  endtask

  // Scoreboard monitor: occupancy/status each cycle, head event on every handshake
  always @(negedge clock) begin
    if (reset) begin
      checkOutput("fifoCount", 32'(fifo_count), 32'(mCount));
      checkOutput("outValid", 32'(out_valid), 32'(mCount > 0));
      checkOutput("dropCnt", 32'(drop_cnt), 32'(mDrop));
      checkOutput("underflow", 32'(underflow), 32'(mUnderflow));
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("scoreboardUnderrun", 32'(expQ.size()), 32'd1);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("evtKind", 32'(out_kind), 32'(e.kind));
          checkOutput("evtPc", out_pc, e.pc);
          checkOutput("evtTarget", out_target, e.target);
          checkOutput("evtDepth", 32'(out_depth), 32'(e.depth));
        end
      end
    end
  end

  task automatic modelReset();
    mCount = 0;
    mDepth = 0;
    mDrop = 0;
    mUnderflow = 1'b0;
    expQ.delete();
  endtask

  initial begin
    reset = 1'b0;
    commit_valid = 1'b0;
    commit_pc = '0;
    commit_nextpc = '0;
    commit_inst = '0;
    out_ready = 1'b0;
    modelReset();
    @(negedge clock);
    checkOutput("rstOutValid", 32'(out_valid), 32'd0);
    checkOutput("rstFifoCount", 32'(fifo_count), 32'd0);
    checkOutput("rstDropCnt", 32'(drop_cnt), 32'd0);
    checkOutput("rstUnderflow", 32'(underflow), 32'd0);
    @(posedge clock);
    #1 reset = 1'b1;

    // jal ra then ret: call depth 0, ret depth 0
    callAt(32'h80000000, 1'b0);
    @(negedge clock);
    checkOutput("t1VisibleNextCycle", 32'(out_valid), 32'd1);
    retAt(32'h80000100, 1'b1);
    idle(1'b1, 4);

    // three nested calls held, then three returns and release
    callAt(32'h80001000, 1'b0);
    callAt(32'h80002000, 1'b0);
    callAt(32'h80003000, 1'b0);
    @(negedge clock);
    checkOutput("t2Count3", 32'(fifo_count), 32'd3);
    retAt(32'h80003100, 1'b0);
    retAt(32'h80002100, 1'b0);
    retAt(32'h80001100, 1'b0);
    idle(1'b1, 8);

    // return at depth 0
    retAt(32'h80004000, 1'b1);
    @(negedge clock);
    checkOutput("t4Underflow", 32'(underflow), 32'd1);
    callAt(32'h80004100, 1'b1);
    idle(1'b1, 4);
    checkOutput("t4Sticky", 32'(underflow), 32'd1);

    // tail-call candidate and non-events
    applyStimulus(1'b1, 32'h80005000, 32'h80006000, 32'h00078067, 1'b1);
    applyStimulus(1'b1, 32'h80005004, 32'h80005008, 32'h00B50533, 1'b1);
    applyStimulus(1'b1, 32'h80005008, 32'h8000500C, 32'h0004A283, 1'b1);
    applyStimulus(1'b1, 32'h8000500C, 32'h8000500C, 32'h0000006F, 1'b1);
    idle(1'b1, 4);
    checkOutput("t5Empty", 32'(fifo_count), 32'd0);

    // overflow: DEPTH+2 held calls, then push at full with pop
    for (int i = 0; i < DEPTH + 2; i++) callAt(32'h80010000 + 32'(i * 4), 1'b0);
    @(negedge clock);
    checkOutput("t3CountFull", 32'(fifo_count), 32'(DEPTH));
    checkOutput("t3Drops", 32'(drop_cnt), 32'd2);
    callAt(32'h80020000, 1'b1);
    @(negedge clock);
    checkOutput("t3CountStays", 32'(fifo_count), 32'(DEPTH));
    idle(1'b1, DEPTH + 4);

    // reset with events queued
    for (int i = 0; i < 5; i++) callAt(32'h80030000 + 32'(i * 4), 1'b0);
    reset = 1'b0;
    modelReset();
    @(negedge clock);
    checkOutput("t6OutValid", 32'(out_valid), 32'd0);
    checkOutput("t6FifoCount", 32'(fifo_count), 32'd0);
    checkOutput("t6DropCnt", 32'(drop_cnt), 32'd0);
    @(posedge clock);
    #1 reset = 1'b1;

    // randomized mix of jumps, returns and ordinary instructions
    for (int i = 0; i < 600; i++) begin
      logic [31:0] inst;
      logic [31:0] pc;
      logic [4:0]  reg1;
      pc   = {$urandom_range(0, 32'h3FFFFFFF), 2'b00};
      reg1 = ($urandom_range(0, 1) == 0) ? 5'd1 : 5'd5;
      case ($urandom_range(0, 7))
        0: inst = {$urandom_range(0, 20'hFFFFF) , 5'd1, 7'h6F} & 32'hFFFFFFFF;
        1: inst = {12'($urandom), 5'($urandom), 3'b000, 5'd5, 7'h67};
        2, 7: inst = {12'd0, reg1, 3'b000, 5'd0, 7'h67};
        3: inst = {12'($urandom), 5'($urandom_range(6, 31)), 3'b000, 5'd0, 7'h67};
        4: inst = {12'($urandom_range(1, 4095)), reg1, 3'b000, 5'd0, 7'h67};
        5: inst = {20'($urandom), 5'd0, 7'h6F};
        default: inst = {25'($urandom), ($urandom_range(0, 1) == 0) ? 7'h33 : 7'h03};
      endcase
      applyStimulus($urandom_range(0, 99) < 85, pc, 32'($urandom), inst, $urandom_range(0, 1) == 1);
    end
    idle(1'b1, DEPTH + 4);
    checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
